// File: rtl/pixel_fb_writer.sv
// Framebuffer writer: background substitution, XY-to-linear address, FWFT pixel FIFO,
// ready/valid write port with sticky overflow and per-frame completion pulse.
module pixel_fb_writer #(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 180,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       x_in,
    input  logic [10:0]       y_in,
    input  logic              block_visible_in,
    input  logic [3:0]        r_in,
    input  logic [3:0]        g_in,
    input  logic [3:0]        b_in,
    input  logic              valid_in,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic              a_valid_q, a_valid_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;

    logic               in_range_c;
    logic               push_c;
    logic               pop_c;
    logic               drop_c;
    logic [ENTRY_W-1:0] head_c;

    // Input stage: range check, colour select and linear address.
    always_comb begin
        in_range_c = (32'(x_in) < H_RES) && (32'(y_in) < V_RES);
        a_valid_d  = valid_in && in_range_c;
        a_addr_d   = ADDR_W'(32'(y_in) * H_RES + 32'(x_in));
        a_data_d   = block_visible_in ? {r_in, g_in, b_in} : BG_COLOR;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_valid_q <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        fb_we    = (count_q != '0);
        head_c   = mem_q[rd_ptr_q];
        fb_addr  = fb_we ? head_c[ENTRY_W-1:DATA_W] : '0;
        fb_data  = fb_we ? head_c[DATA_W-1:0] : '0;
        pop_c    = fb_we && fb_ready;
        push_c   = a_valid_q && ((count_q != FULL_CNT) || pop_c);
        drop_c   = a_valid_q && (count_q == FULL_CNT) && !pop_c;

        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        frame_done_d = pop_c && (fb_addr == LAST_ADDR);
        overflow_d   = overflow_q || drop_c;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && push_c) begin
            mem_q[wr_ptr_q] <= {a_addr_q, a_data_q};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: latency, background/range handling, backpressure,
// full-with-pop, full raster frame and mid-burst reset.
module tb_pixel_fb_writer;

    localparam int unsigned H_RES  = 320;
    localparam int unsigned V_RES  = 180;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned NPIX   = H_RES * V_RES;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [10:0]       x_in = '0;
    logic [10:0]       y_in = '0;
    logic              block_visible_in = 1'b0;
    logic [3:0]        r_in = '0;
    logic [3:0]        g_in = '0;
    logic [3:0]        b_in = '0;
    logic              valid_in = 1'b0;
    logic [ADDR_W-1:0] fb_addr;
    logic [11:0]       fb_data;
    logic              fb_we;
    logic              fb_ready = 1'b1;
    logic              frame_done;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [11:0]       log_data[$];
    int                fd_count = 0;
    int                fd_good  = 0;
    logic              prev_last = 1'b0;

    pixel_fb_writer #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .FIFO_DEPTH(16), .BG_COLOR(12'h000)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .block_visible_in(block_visible_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .valid_in(valid_in), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
        .fb_ready(fb_ready), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    // Transfer and frame_done monitor, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (frame_done) begin
            fd_count = fd_count + 1;
            if (prev_last) fd_good = fd_good + 1;
        end
        prev_last = !rst_in && fb_we && fb_ready && (fb_addr == ADDR_W'(NPIX - 1));
        if (!rst_in && fb_we && fb_ready) begin
            log_addr.push_back(fb_addr);
            log_data.push_back(fb_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic vis, input logic [11:0] rgb);
        x_in = 11'(x);
        y_in = 11'(y);
        block_visible_in = vis;
        {r_in, g_in, b_in} = rgb;
        valid_in = 1'b1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 200 && fb_we; t++) tick();
        check(tag, 32'(fb_we), 32'd0);
    endtask

    initial begin
        int base;
        int bad;

        // Reset state
        do_reset();
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Single pixel latency: (5,2) -> 2*320+5 = 645
        base = log_addr.size();
        drive(5, 2, 1'b1, 12'hF81);
        tick();
        valid_in = 1'b0;
        check("lat_n", 32'(fb_we), 32'd0);
        tick();
        check("lat_n1_we", 32'(fb_we), 32'd1);
        check("lat_addr", 32'(fb_addr), 32'd645);
        check("lat_data", 32'(fb_data), 32'hF81);
        tick();
        check("lat_once", 32'(fb_we), 32'd0);
        check("lat_cnt", 32'(log_addr.size() - base), 32'd1);

        // Background colour, then out-of-range pixel discarded
        base = log_addr.size();
        drive(0, 0, 1'b0, 12'hFFF);
        tick();
        drive(320, 0, 1'b1, 12'h123);
        tick();
        valid_in = 1'b0;
        repeat (4) tick();
        check("bg_cnt", 32'(log_addr.size() - base), 32'd1);
        if (log_addr.size() > base) begin
            check("bg_addr", 32'(log_addr[base]), 32'd0);
            check("bg_data", 32'(log_data[base]), 32'h000);
        end
        check("oor_ovf", 32'(overflow), 32'd0);

        // Backpressure: 20 pixels, 16 kept, 4 dropped
        base = log_addr.size();
        fb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(i, 0, 1'b1, {4'(i), 4'hC, 4'h3});
            tick();
        end
        valid_in = 1'b0;
        tick();
        tick();
        check("bp_ovf", 32'(overflow), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_we", 32'(fb_we), 32'd1);
            check("bp_hold_addr", 32'(fb_addr), 32'd0);
            check("bp_hold_data", 32'(fb_data), 32'h0C3);
            tick();
        end
        fb_ready = 1'b1;
        drain("bp_drain");
        check("bp_cnt", 32'(log_addr.size() - base), 32'd16);
        for (int i = 0; i < 16 && base + i < log_addr.size(); i++) begin
            check("bp_addr", 32'(log_addr[base + i]), 32'(i));
            check("bp_data", 32'(log_data[base + i]), {20'd0, 4'(i), 4'hC, 4'h3});
        end
        check("bp_ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous pop: pop begins exactly when FIFO holds 16
        base = log_addr.size();
        fb_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 17) fb_ready = 1'b1;
            drive(100 + i, 1, 1'b1, {4'(i), 4'h5, 4'hA});
            tick();
        end
        valid_in = 1'b0;
        drain("fp_drain");
        check("fp_ovf", 32'(overflow), 32'd0);
        check("fp_cnt", 32'(log_addr.size() - base), 32'd32);
        bad = 0;
        for (int i = 0; i < 32 && base + i < log_addr.size(); i++) begin
            if (log_addr[base + i] != ADDR_W'(420 + i)) bad++;
            if (log_data[base + i] != {4'(i), 4'h5, 4'hA}) bad++;
        end
        check("fp_order", 32'(bad), 32'd0);

        // Full raster frame
        do_reset();
        base = log_addr.size();
        fd_count = fd_count;
        begin
            int fd0;
            int fg0;
            fd0 = fd_count;
            fg0 = fd_good;
            for (int y = 0; y < int'(V_RES); y++) begin
                for (int x = 0; x < int'(H_RES); x++) begin
                    drive(x, y, 1'b1, {4'(x), 4'(y), 4'h7});
                    tick();
                end
            end
            valid_in = 1'b0;
            repeat (8) tick();
            check("ff_cnt", 32'(log_addr.size() - base), 32'(NPIX));
            bad = 0;
            for (int k = 0; k < int'(NPIX) && base + k < log_addr.size(); k++) begin
                if (log_addr[base + k] != ADDR_W'(k)) bad++;
            end
            check("ff_order", 32'(bad), 32'd0);
            check("ff_fd_cnt", 32'(fd_count - fd0), 32'd1);
            check("ff_fd_pos", 32'(fd_good - fg0), 32'd1);
            check("ff_ovf", 32'(overflow), 32'd0);
        end

        // Mid-burst reset flushes queued pixels
        fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(i, 3, 1'b1, 12'hABC);
            tick();
        end
        valid_in = 1'b0;
        tick();
        check("mr_pre_we", 32'(fb_we), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("mr_we", 32'(fb_we), 32'd0);
        base = log_addr.size();
        fb_ready = 1'b1;
        repeat (6) tick();
        check("mr_cnt", 32'(log_addr.size() - base), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_fd", 32'(frame_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Downstream consumer of the per-pixel shading pipeline's final RGB stage output (x/y, visibility, 4-bit RGB, valid strobe).
- Substitutes a background colour for non-visible pixels, converts XY to a linear framebuffer address, buffers pixels in a small FIFO, and writes them to a framebuffer BRAM port under ready/valid backpressure.
- Upstream cannot stall, so the block reports overflow and signals completion of each frame.

Parameters:
- H_RES, 320: horizontal resolution in pixels.
- V_RES, 180: vertical resolution in pixels.
- ADDR_W, 16: framebuffer address width. Must satisfy 2^ADDR_W >= H_RES*V_RES.
- FIFO_DEPTH, 16: pixel FIFO entries. Must be a power of two, >= 2.
- BG_COLOR, 12'h000: {r,g,b} written for non-visible pixels.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-high.
- x_in  input  11  pixel column.
- y_in  input  11  pixel row.
- block_visible_in  input  1  1 = use r/g/b_in; 0 = use BG_COLOR.
- r_in  input  4  red.
- g_in  input  4  green.
- b_in  input  4  blue.
- valid_in  input  1  pixel strobe; inputs are sampled only when high.
- fb_addr  output  ADDR_W  linear address, y*H_RES + x.
- fb_data  output  12  {r,g,b}.
- fb_we  output  1  write request; high whenever the FIFO is non-empty.
- fb_ready  input  1  framebuffer accepts the write this cycle.
- frame_done  output  1  one-cycle pulse after the last pixel is written.
- overflow  output  1  sticky; a pixel was dropped.

Behaviour:
- One clock domain (clk_in); synchronous active-high reset on rst_in.
- Reset values: fb_we=0, fb_addr=0, fb_data=0, frame_done=0, overflow=0; FIFO empty (pointers and count = 0); input stage valid = 0.
- Reset asserted mid-operation flushes all buffered pixels with no writes issued. Reset wins over every simultaneous event.
- Stage A (1 register), on valid_in:
  - Range check: x_in >= H_RES or y_in >= V_RES -> pixel discarded silently. Not counted as overflow.
  - Colour select: block_visible_in ? {r_in,g_in,b_in} : BG_COLOR.
  - Address: y_in*H_RES + x_in, computed exactly and truncated to ADDR_W (never overflows given the parameter constraint).
  - The multiply may be a constant multiply. Latency is exactly 1 register regardless.
- FIFO: first-word-fall-through.
  - Push when stage A holds a valid in-range pixel.
  - Pop when fb_we && fb_ready.
  - fb_addr/fb_data present the head entry combinationally from FIFO storage; they are 0 or don't-care when empty.
  - Bench checks fb_addr/fb_data only while fb_we=1.
- Latency: valid_in sampled at edge N -> fb_we=1 with that pixel during cycle N+2 (FIFO empty, no contention).
- Ordering: pixels are written strictly in arrival order. No reordering, no coalescing of duplicate addresses; last write wins in the framebuffer.
- Full handling:
  - Push while count==FIFO_DEPTH and no pop in the same cycle -> incoming pixel dropped, overflow set to 1.
  - overflow clears only on reset.
  - Push and pop in the same cycle while full -> both occur, no drop, count unchanged.
- Empty handling:
  - Push and pop in the same cycle while empty is impossible; the pixel appears the following cycle.
  - fb_we is never asserted while empty.
- Handshake: fb_we, fb_addr and fb_data remain stable while fb_we=1 && fb_ready=0. fb_we never drops without a completed transfer.
- frame_done:
  - Asserted for exactly one cycle, the cycle after a completed transfer whose address = H_RES*V_RES-1.
  - Back-to-back frames produce separate pulses.
  - Triggered by address only, not by a pixel count.
- Throughput: 1 pixel/cycle sustained when fb_ready is held high.

Test Plan:
- Single pixel: x=5, y=2, visible, rgb=F/8/1, fb_ready=1 -> fb_we high exactly at cycle N+2, fb_addr=645, fb_data=12'hF81, one cycle only.
- Non-visible plus out-of-range: visible=0 at (0,0) then x=320,y=0 valid -> one write, addr 0, data=BG_COLOR. No second write; overflow stays 0.
- Backpressure: 20-pixel burst with fb_ready=0 -> first 16 buffered, 4 dropped, overflow=1, fb_we held with addr/data stable. Release fb_ready -> exactly 16 in-order writes; overflow remains 1 until reset.
- Full with simultaneous pop: fill to 16, then hold fb_ready=1 while streaming 1 pixel/cycle -> no drops, count stays 16, overflow=0.
- Full frame: raster scan of 57600 pixels with fb_ready=1 -> 57600 writes, addresses 0..57599 in order. frame_done pulses once, the cycle after addr 57599.
- Mid-burst reset: 8 pixels queued with fb_ready=0, assert rst_in 1 cycle -> fb_we=0 next cycle, no writes after reset release, overflow=0, frame_done=0.
